// File: rtl/int_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | int_ctrl_pkg : register offsets, bus FSM states and source indices    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package int_ctrl_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CAUSE   = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  typedef enum logic [0:0] {
    BUS_IDLE  = 1'b0,
    BUS_ACKED = 1'b1
  } bus_state_t;

  localparam int KEYBOARD = 3;
  localparam int SWITCH   = 5;
  localparam int COUNTER  = 4;
  localparam int DISK     = 1;

endpackage

`default_nettype wire

// File: rtl/int_ctrl_irq_sync_edge.sv
// +----------------------------------------------------------------------+
// | irq_sync_edge : per-source synchroniser chain and rising-edge detect  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync[s] <= sync[s-1];
      end
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// +----------------------------------------------------------------------+
// | int_ctrl : Wishbone-programmable interrupt controller (INT / CAUSE)   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] w1c;
  logic             en;

  bus_state_t       state;
  bus_state_t       state_nxt;
  logic             txn_start;
  logic             wr_commit;
  logic [1:0]       reg_sel;

  logic [31:0]      rd_data;
  logic [31:0]      pend_ext;
  logic [31:0]      mask_ext;
  logic [31:0]      cause_nxt;
  logic             int_nxt;
  logic             unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  assign reg_sel     = ADDR[3:2];
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

  // Bus handshake: a transaction starts (and any write commits) only on the IDLE->ACKED edge.
  always_ff @(posedge clk) begin
    if (rst) state <= BUS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    txn_start = 1'b0;
    case (state)
      BUS_IDLE: begin
        if (STB) begin
          state_nxt = BUS_ACKED;
          txn_start = 1'b1;
        end
      end
      BUS_ACKED: begin
        if (!STB) state_nxt = BUS_IDLE;
      end
      default: state_nxt = BUS_IDLE;
    endcase
  end

  assign ACK       = (state == BUS_ACKED);
  assign wr_commit = txn_start & WE;

  always_comb begin
    pend_ext = '0;
    mask_ext = '0;
    pend_ext[N_SRC-1:0] = pending;
    mask_ext[N_SRC-1:0] = mask;
    case (reg_sel)
      REG_PENDING: rd_data = pend_ext;
      REG_MASK:    rd_data = mask_ext;
      REG_CAUSE:   rd_data = CAUSE;
      default:     rd_data = {31'd0, en};
    endcase
  end

  assign w1c = (wr_commit && reg_sel == REG_PENDING) ? DAT_I[N_SRC-1:0] : '0;
  assign act = pending & mask & {N_SRC{en}};

  // Scan from the top so the lowest active index is the one left in cause_nxt.
  always_comb begin
    cause_nxt = '0;
    int_nxt   = |act;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) cause_nxt = 32'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      en      <= 1'b0;
      DAT_O   <= '0;
      INT     <= 1'b0;
      CAUSE   <= '0;
    end else begin
      // A new edge beats a simultaneous clear of the same bit.
      pending <= (pending & ~w1c) | rise;
      if (wr_commit && reg_sel == REG_MASK) mask <= DAT_I[N_SRC-1:0];
      if (wr_commit && reg_sel == REG_CTRL) en   <= DAT_I[0];
      if (txn_start) DAT_O <= rd_data;
      INT   <= int_nxt;
      CAUSE <= cause_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_int_ctrl : directed bench with a cycle-level reference model       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_int_ctrl;

  localparam int N  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irq = '0;
  logic          STB = 1'b0;
  logic          WE  = 1'b0;
  logic [31:0]   ADDR = '0;
  logic [31:0]   DAT_I = '0;
  logic [31:0]   DAT_O;
  logic          ACK;
  logic          INT;
  logic [31:0]   CAUSE;

  int compared   = 0;
  int mismatched = 0;
  bit cmp_en     = 1'b0;

  int_ctrl #(.N_SRC(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .irq_in(irq),
    .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK(ACK), .INT(INT), .CAUSE(CAUSE)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Reference model: registers as plain variables, irq samples kept as a short history.
  logic [N-1:0] m_pend = '0, m_mask = '0;
  logic         m_en = 1'b0, m_int = 1'b0, m_ack = 1'b0, m_busy = 1'b0;
  logic [31:0]  m_cause = '0, m_dat = '0;
  logic [N-1:0] h [0:SS];

  initial begin
    for (int j = 0; j <= SS; j++) h[j] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pend = '0; m_mask = '0; m_en = 1'b0; m_int = 1'b0; m_cause = '0;
        m_ack = 1'b0; m_busy = 1'b0; m_dat = '0;
        for (int j = 0; j <= SS; j++) h[j] = '0;
      end else begin
        logic [N-1:0] act_v, rise_v, clr_v;
        logic [31:0]  rd_v;
        rise_v = h[SS-1] & ~h[SS];
        act_v  = m_en ? (m_pend & m_mask) : '0;
        clr_v  = '0;
        if (!m_busy && STB) begin
          case (ADDR[3:2])
            2'd0:    rd_v = 32'(m_pend);
            2'd1:    rd_v = 32'(m_mask);
            2'd2:    rd_v = m_cause;
            default: rd_v = {31'd0, m_en};
          endcase
          m_dat = rd_v; m_ack = 1'b1; m_busy = 1'b1;
          if (WE) begin
            if (ADDR[3:2] == 2'd0) clr_v  = DAT_I[N-1:0];
            if (ADDR[3:2] == 2'd1) m_mask = DAT_I[N-1:0];
            if (ADDR[3:2] == 2'd3) m_en   = DAT_I[0];
          end
        end else if (m_busy && !STB) begin
          m_busy = 1'b0; m_ack = 1'b0;
        end
        m_int   = (act_v != '0);
        m_cause = 32'd0;
        for (int i = 0; i < N; i++) begin
          if (act_v[i]) begin
            m_cause = 32'(i);
            break;
          end
        end
        m_pend = (m_pend & ~clr_v) | rise_v;
        for (int j = SS; j > 0; j--) h[j] = h[j-1];
        h[0] = irq;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("model_ack",   {31'd0, ACK}, {31'd0, m_ack});
        check("model_int",   {31'd0, INT}, {31'd0, m_int});
        check("model_cause", CAUSE, m_cause);
        if (m_ack) check("model_dat_o", DAT_O, m_dat);
      end
    end
  end

  // Called at a negedge; returns at the negedge after ACK has dropped.
  task automatic bus_xfer(input bit we, input logic [1:0] a, input logic [31:0] d,
                          input int hold, output logic [31:0] rd);
    int n;
    STB = 1'b1; WE = we; ADDR = {28'd0, a, 2'b00}; DAT_I = d;
    n = 0;
    @(negedge clk); n++;
    while (ACK !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
    end
    check("ack_latency", 32'(n), 32'd1);
    rd = DAT_O;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("ack_hold", {31'd0, ACK}, 32'd1);
    end
    STB = 1'b0; WE = 1'b0;
    @(negedge clk);
    check("ack_drop", {31'd0, ACK}, 32'd0);
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [31:0] expected, input string name);
    logic [31:0] r;
    bus_xfer(1'b0, a, 32'd0, 1, r);
    check(name, r, expected);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_xfer(1'b1, a, d, 1, r);
  endtask

  task automatic chk_out(input string name, input logic i_exp, input logic [31:0] c_exp);
    check({name, "_int"},   {31'd0, INT}, {31'd0, i_exp});
    check({name, "_cause"}, CAUSE, c_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ack",   {31'd0, ACK}, 32'd0);
    check("reset_dat_o", DAT_O, 32'd0);
    chk_out("reset", 1'b0, 32'd0);
    rd_reg(2'd0, 32'd0, "reset_pending");
    rd_reg(2'd1, 32'd0, "reset_mask");
    rd_reg(2'd2, 32'd0, "reset_cause");
    rd_reg(2'd3, 32'd0, "reset_ctrl");

    // Single pulse on source 5: INT/CAUSE appear three edges after first sample.
    wr_reg(2'd1, 32'h28);
    wr_reg(2'd3, 32'h1);
    irq[5] = 1'b1;
    @(negedge clk);
    irq[5] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("pulse5_k2", 1'b0, 32'd0);
    @(negedge clk);
    chk_out("pulse5_k3", 1'b1, 32'd5);
    rd_reg(2'd0, 32'h20, "pulse5_pending");
    rd_reg(2'd2, 32'd5, "pulse5_cause_reg");
    wr_reg(2'd0, 32'h20);
    chk_out("pulse5_cleared", 1'b0, 32'd0);

    // Sources 3 and 5 together: priority then sequential clears.
    irq[3] = 1'b1; irq[5] = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("both_pend", 1'b1, 32'd3);
    wr_reg(2'd0, 32'h08);
    chk_out("clr3", 1'b1, 32'd5);
    wr_reg(2'd0, 32'h20);
    chk_out("clr5", 1'b0, 32'd0);
    rd_reg(2'd0, 32'h00, "held_no_retrigger");
    irq[3] = 1'b0; irq[5] = 1'b0;
    repeat (3) @(negedge clk);

    // Masked pending stays latched; unmasking raises INT.
    wr_reg(2'd1, 32'h00);
    irq[3] = 1'b1;
    @(negedge clk);
    irq[3] = 1'b0;
    repeat (4) @(negedge clk);
    chk_out("masked", 1'b0, 32'd0);
    rd_reg(2'd0, 32'h08, "masked_pending");
    wr_reg(2'd1, 32'h08);
    chk_out("unmasked", 1'b1, 32'd3);

    // Clear source 3, then let a new edge land on the same edge as its W1C.
    wr_reg(2'd0, 32'h08);
    chk_out("pre_race", 1'b0, 32'd0);
    irq[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_xfer(1'b1, 2'd0, 32'h08, 1, r);
    rd_reg(2'd0, 32'h08, "race_set_wins");
    chk_out("race", 1'b1, 32'd3);
    irq[3] = 1'b0;

    // Long strobe on a MASK write, with a bit above N_SRC to confirm it reads back 0.
    bus_xfer(1'b1, 2'd1, 32'h128, 5, r);
    check("long_wr_old_mask", r, 32'h08);
    rd_reg(2'd1, 32'h28, "long_wr_mask");
    rd_reg(2'd3, 32'h01, "ctrl_en");

    // Reset while ACK is high during a MASK write.
    STB = 1'b1; WE = 1'b1; ADDR = {28'd0, 2'd1, 2'b00}; DAT_I = 32'hFF;
    @(negedge clk);
    check("rst_mid_ack_high", {31'd0, ACK}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ack_low", {31'd0, ACK}, 32'd0);
    STB = 1'b0; WE = 1'b0; rst = 1'b0;
    @(negedge clk);
    rd_reg(2'd1, 32'd0, "rst_mid_mask");
    rd_reg(2'd0, 32'd0, "rst_mid_pending");
    rd_reg(2'd3, 32'd0, "rst_mid_ctrl");
    chk_out("rst_mid", 1'b0, 32'd0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Bus-programmable interrupt controller that replaces the fixed combinational INT/CAUSE priority mux in front of the multi-cycle CPU.
- Synchronises up to N_SRC level interrupt sources (keyboard, switch, counter, disk, ...).
- Latches rising edges into pending bits and applies a per-source mask plus a global enable.
- Presents a registered INT and a 32-bit CAUSE (source index) to the CPU.
- Attaches as one more slave on the Wishbone interconnect, so software can read, mask and clear pending interrupts.

Parameters:
N_SRC, 8, number of interrupt sources (1..32)
SYNC_STAGES, 2, synchroniser flops per source (>=1)

Ports:
clk  in  1  system clock (single domain)
rst  in  1  synchronous, active-high reset
irq_in  in  N_SRC  level interrupt requests, may be asynchronous
STB  in  1  bus strobe, held high by master until ACK
WE  in  1  bus write enable, valid with STB
ADDR  in  32  byte address; only ADDR[3:2] decoded
DAT_I  in  32  write data
DAT_O  out  32  read data, valid while ACK high
ACK  out  1  bus acknowledge
INT  out  1  interrupt request to CPU
CAUSE  out  32  index of highest-priority active source

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state is updated on the rising edge of clk.
- Reset values:
  - PENDING=0, MASK=0, CTRL.EN=0, synchroniser and edge-history flops=0.
  - ACK=0, DAT_O=0, INT=0, CAUSE=0.
- Edge capture:
  - Per source, a SYNC_STAGES flop chain feeds an edge-history flop.
  - PENDING[i] sets when the synchronised value is 1 and the history value is 0.
  - Latency with SYNC_STAGES=2: input first sampled high at edge k, PENDING set at edge k+2, INT/CAUSE updated at edge k+3.
- Active vector: ACT = PENDING & MASK, gated by CTRL.EN.
- Outputs:
  - INT (registered) = |ACT.
  - CAUSE (registered) = zero-extended lowest set index in ACT. Index 0 has the highest priority.
  - CAUSE=0 when ACT=0.
- Register map (ADDR[3:2]):
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: read/write, bits >= N_SRC read 0.
  - 2 CAUSE: read-only, current registered CAUSE; reading it does not clear anything.
  - 3 CTRL: bit0 EN read/write, other bits read 0.
- Bus handshake, FSM IDLE -> ACKED -> IDLE:
  - IDLE, STB=1: ACK goes high on the next edge. DAT_O is loaded with the selected register. A write commits on that same edge, exactly once per transaction.
  - ACKED: ACK stays high while STB=1. When STB is sampled 0, ACK drops on the next edge and the FSM returns to IDLE.
  - A new transaction needs STB low for at least one cycle in between.
- Simultaneous events:
  - Rising edge on source i in the same cycle as a W1C of bit i: set wins, so PENDING[i]=1.
  - MASK written in the same cycle a source becomes pending: INT/CAUSE reflect the new MASK one edge later.
- Masked pending bits stay latched. Unmasking an already-pending source raises INT on the edge after the MASK write commits.
- A level held high does not re-trigger. Software must clear PENDING, and the source must fall and rise again.
- Reset mid-transaction: ACK drops and FSM=IDLE on the reset edge; the aborted write is not committed.

Decomposition:
- Shared package int_ctrl_pkg:
  - register offsets (REG_PENDING=2'd0, REG_MASK=2'd1, REG_CAUSE=2'd2, REG_CTRL=2'd3)
  - bus FSM state encoding
  - default source index constants: KEYBOARD=3, SWITCH=5, COUNTER=4, DISK=1
- Sub-module irq_sync_edge: per-source synchroniser plus rising-edge detector, instantiated N_SRC times via generate.
- The priority encoder stays inline.

Test Plan:
- Reset, then read all four registers -> every read returns 0, INT=0, CAUSE=0, and ACK rises exactly one edge after STB.
- Write MASK=0x28, CTRL=1, pulse irq_in[5] high for 1 cycle -> PENDING=0x20, INT=1 and CAUSE=5 three edges after first sample; write PENDING=0x20 -> INT=0 on the following edge.
- Pend sources 3 and 5 together with MASK=0x28, EN=1 -> CAUSE=3; W1C bit 3 -> CAUSE=5 and INT stays 1; W1C bit 5 -> INT=0, CAUSE=0.
- irq_in[3] pending with MASK=0 -> INT=0 and PENDING reads 0x08; write MASK=0x08 -> INT=1, CAUSE=3 one edge after the write ACK.
- Rising edge on irq_in[3] arrives at the PENDING register in the same cycle as a W1C of 0x08 -> PENDING[3]=1 afterwards; holding STB high for 5 cycles on a MASK write -> write commits once and ACK stays high all 5 cycles.
- Assert rst while ACK=1 during a MASK write of 0xFF -> ACK=0 next edge and MASK reads 0 after reset.
